// File: rtl/bnn_acc_if.sv
// Data-memory bus between the RISC-V core/memory and the BNN accelerator.
// The accelerator decodes CPU addresses and masters memory while busy.
interface bnn_acc_if;
   logic [31:0] addr_in;
   logic [31:0] data_in;
   logic [31:0] data_mem;
   logic        enable;
   logic [31:0] data_out;
   logic        wenb;
   logic        renb;
   logic [15:2] addr_mem;
   logic [3:0]  webb_out;

   modport master (
      output addr_in, data_in, data_mem,
      input  enable, data_out, wenb, renb, addr_mem, webb_out
   );

   modport slave (
      input  addr_in, data_in, data_mem,
      output enable, data_out, wenb, renb, addr_mem, webb_out
   );
endinterface

// File: rtl/bnn_acc.sv
// BNN accelerator: memory-mapped config, then one XNOR-popcount dot product
// over count 32-bit words, result written back as a 16-bit word.
module bnn_acc #(
   parameter logic [31:0] IN_REG_ADDR   = 32'h0008_0000,
   parameter logic [31:0] W_REG_ADDR    = 32'h000C_0000,
   parameter logic [31:0] CTRL_REG_ADDR = 32'h0010_0000,
   parameter logic [31:0] OUT_REG_ADDR  = 32'h0014_0000
) (
   input  logic     clk,
   input  logic     rst_n,   // active-high despite the name
   bnn_acc_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LD_X, LD_W, MAC, WR, DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] in_base_q, in_base_d;
   logic [31:0] w_base_q, w_base_d;
   logic [31:0] out_addr_q, out_addr_d;
   logic [31:0] x_q, x_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  index_q, index_d;
   logic [15:0] acc_q, acc_d;

   function automatic logic [5:0] popcnt(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) n = n + {5'b0, v[i]};
      return n;
   endfunction

   logic [31:0] x_addr, w_addr;
   logic [5:0]  match_cnt;
   logic        unused_addr_bits;

   assign x_addr    = in_base_q + {22'b0, index_q, 2'b00};
   assign w_addr    = w_base_q + {22'b0, index_q, 2'b00};
   assign match_cnt = popcnt(~(x_q ^ bus.data_mem));
   assign unused_addr_bits = ^{x_addr[31:16], x_addr[1:0], w_addr[31:16], w_addr[1:0],
                               out_addr_q[31:16], out_addr_q[1:0]};

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= IDLE;
         in_base_q  <= '0;
         w_base_q   <= '0;
         out_addr_q <= '0;
         x_q        <= '0;
         count_q    <= '0;
         index_q    <= '0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_base_q  <= in_base_d;
         w_base_q   <= w_base_d;
         out_addr_q <= out_addr_d;
         x_q        <= x_d;
         count_q    <= count_d;
         index_q    <= index_d;
         acc_q      <= acc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      in_base_d  = in_base_q;
      w_base_d   = w_base_q;
      out_addr_d = out_addr_q;
      x_d        = x_q;
      count_d    = count_q;
      index_d    = index_q;
      acc_d      = acc_q;
      case (state_q)
         IDLE: begin
            if (bus.addr_in == IN_REG_ADDR)  in_base_d  = bus.data_in;
            if (bus.addr_in == W_REG_ADDR)   w_base_d   = bus.data_in;
            if (bus.addr_in == OUT_REG_ADDR) out_addr_d = bus.data_in;
            if (bus.addr_in == CTRL_REG_ADDR) begin
               count_d = (bus.data_in[15:8] == 8'd0) ? 8'd1 : bus.data_in[15:8];
               if (bus.data_in[0]) begin
                  acc_d   = '0;
                  index_d = '0;
                  state_d = LD_X;
               end
            end
         end
         LD_X: state_d = LD_W;
         LD_W: begin
            // x read issued in LD_X lands now; w read issued now lands in MAC
            x_d     = bus.data_mem;
            state_d = MAC;
         end
         MAC: begin
            acc_d   = acc_q + {10'b0, match_cnt};
            index_d = index_q + 8'd1;
            state_d = ({1'b0, index_q} + 9'd1 == {1'b0, count_q}) ? WR : LD_X;
         end
         WR:   state_d = DONE;
         DONE: if (bus.addr_in != CTRL_REG_ADDR) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.enable   = 1'b0;
      bus.renb     = 1'b0;
      bus.wenb     = 1'b0;
      bus.webb_out = 4'b0000;
      bus.addr_mem = '0;
      bus.data_out = '0;
      case (state_q)
         LD_X: begin
            bus.enable   = 1'b1;
            bus.renb     = 1'b1;
            bus.addr_mem = x_addr[15:2];
         end
         LD_W: begin
            bus.enable   = 1'b1;
            bus.renb     = 1'b1;
            bus.addr_mem = w_addr[15:2];
         end
         MAC: bus.enable = 1'b1;
         WR: begin
            bus.enable   = 1'b1;
            bus.wenb     = 1'b1;
            bus.webb_out = 4'b1111;
            bus.addr_mem = out_addr_q[15:2];
            bus.data_out = {16'b0, acc_q};
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_bnn_acc.sv
// Directed bench for bnn_acc: registered memory model plus a bus monitor
// that logs reads, writes and busy cycles for comparison.
module tb_bnn_acc;
   localparam logic [31:0] IN_A   = 32'h0008_0000;
   localparam logic [31:0] W_A    = 32'h000C_0000;
   localparam logic [31:0] CTRL_A = 32'h0010_0000;
   localparam logic [31:0] OUT_A  = 32'h0014_0000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bnn_acc_if bus();
   bnn_acc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [31:0] mem [0:16383];
   initial bus.data_mem = '0;
   always @(posedge clk) if (bus.renb) bus.data_mem <= mem[bus.addr_mem];

   logic [13:0] rd_q[$];
   logic [13:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic [3:0]  wb_q[$];
   int en_cnt  = 0;
   int ovl_cnt = 0;
   always @(posedge clk) begin
      if (bus.renb) rd_q.push_back(bus.addr_mem);
      if (bus.wenb) begin
         wa_q.push_back(bus.addr_mem);
         wd_q.push_back(bus.data_out);
         wb_q.push_back(bus.webb_out);
      end
      if (bus.enable) en_cnt++;
      if (bus.renb && bus.wenb) ovl_cnt++;
   end

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.addr_in = a;
      bus.data_in = d;
      @(negedge clk);
      bus.addr_in = '0;
      bus.data_in = '0;
   endtask

   int rb, wb, eb;

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'hDEAD_BEEF;
      mem[14'h0004] = 32'hFFFF_FFFF;
      mem[14'h0010] = 32'hFFFF_0000;
      for (int k = 0; k < 3; k++) begin
         mem[14'h0040 + k] = 32'hA5A5_A5A5;
         mem[14'h0080 + k] = 32'hA5A5_A5A5;
      end
      mem[14'h0000] = 32'h0000_FFFF;
      bus.addr_in = '0;
      bus.data_in = '0;

      // reset
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_enable", {31'b0, bus.enable}, 32'd0);
      chk("rst_rw", {30'b0, bus.renb, bus.wenb}, 32'd0);
      chk("rst_addr_be", {14'b0, bus.addr_mem, bus.webb_out}, 32'd0);
      chk("rst_data_out", bus.data_out, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("post_rst_enable", {31'b0, bus.enable}, 32'd0);

      // N=1: x=FFFFFFFF, w=FFFF0000 -> 16 matching bits
      wr_reg(IN_A, 32'h10);
      wr_reg(W_A, 32'h40);
      wr_reg(OUT_A, 32'h80);
      rb = rd_q.size(); wb = wa_q.size(); eb = en_cnt;
      wr_reg(CTRL_A, 32'h1);
      chk("n1_enable_rise", {31'b0, bus.enable}, 32'd1);
      repeat (6) @(negedge clk);
      chk("n1_reads", rd_q.size() - rb, 2);
      chk("n1_rd_x", {18'b0, rd_q[rb]}, 32'h4);
      chk("n1_rd_w", {18'b0, rd_q[rb+1]}, 32'h10);
      chk("n1_writes", wa_q.size() - wb, 1);
      chk("n1_wr_addr", {18'b0, wa_q[wb]}, 32'h20);
      chk("n1_wr_data", wd_q[wb], 32'h10);
      chk("n1_wr_be", {28'b0, wb_q[wb]}, 32'hF);
      chk("n1_en_cycles", en_cnt - eb, 4);
      chk("n1_idle", {31'b0, bus.enable}, 32'd0);

      // N=3, all A5A5A5A5 -> 96; IN_REG write during MAC must be ignored
      wr_reg(IN_A, 32'h100);
      wr_reg(W_A, 32'h200);
      wr_reg(OUT_A, 32'h300);
      rb = rd_q.size(); wb = wa_q.size(); eb = en_cnt;
      wr_reg(CTRL_A, 32'h0301);
      @(negedge clk);
      @(negedge clk);
      bus.addr_in = IN_A;
      bus.data_in = 32'h99;
      @(negedge clk);
      bus.addr_in = '0;
      bus.data_in = '0;
      repeat (10) @(negedge clk);
      chk("n3_reads", rd_q.size() - rb, 6);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("n3_rd_x%0d", k), {18'b0, rd_q[rb+2*k]}, 32'h40 + k);
         chk($sformatf("n3_rd_w%0d", k), {18'b0, rd_q[rb+2*k+1]}, 32'h80 + k);
      end
      chk("n3_writes", wa_q.size() - wb, 1);
      chk("n3_wr_addr", {18'b0, wa_q[wb]}, 32'hC0);
      chk("n3_wr_data", wd_q[wb], 32'h60);
      chk("n3_en_cycles", en_cnt - eb, 10);

      // held start address: one run only, in_base still 0x100
      rb = rd_q.size(); wb = wa_q.size(); eb = en_cnt;
      @(negedge clk);
      bus.addr_in = CTRL_A;
      bus.data_in = 32'h1;
      repeat (12) @(negedge clk);
      chk("held_rd_x", {18'b0, rd_q[rb]}, 32'h40);
      chk("held_writes", wa_q.size() - wb, 1);
      chk("held_wr_data", wd_q[wb], 32'h20);
      chk("held_en_cycles", en_cnt - eb, 4);
      bus.addr_in = '0;
      bus.data_in = '0;
      repeat (3) @(negedge clk);
      chk("held_release_en", en_cnt - eb, 4);

      // reset asserted in LD_W
      wb = wa_q.size();
      wr_reg(CTRL_A, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_enable", {31'b0, bus.enable}, 32'd0);
      chk("midrst_renb", {31'b0, bus.renb}, 32'd0);
      chk("midrst_addr", {18'b0, bus.addr_mem}, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst_no_write", wa_q.size() - wb, 0);

      // registers cleared: bases 0, out 0; mem[0] xnor itself -> 32
      rb = rd_q.size(); wb = wa_q.size(); eb = en_cnt;
      wr_reg(CTRL_A, 32'h1);
      repeat (6) @(negedge clk);
      chk("clr_reads", rd_q.size() - rb, 2);
      chk("clr_rd_x", {18'b0, rd_q[rb]}, 32'h0);
      chk("clr_rd_w", {18'b0, rd_q[rb+1]}, 32'h0);
      chk("clr_wr_addr", {18'b0, wa_q[wb]}, 32'h0);
      chk("clr_wr_data", wd_q[wb], 32'h20);
      chk("clr_en_cycles", en_cnt - eb, 4);
      chk("rw_overlap", ovl_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
